// File: rtl/multicycle_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_controller_if                                           |
// | Control/status bundle between the core controller and datapath.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [31:0]        instr;
  logic [3:0]         alu_flags;
`ifdef MEM_HANDSHAKE_EN
  logic               mem_ready;
`endif
  logic               PCWrite;
  logic               AdrSrc;
  logic               MemWrite;
  logic               IRWrite;
  logic               RegWrite;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [1:0]         ALUControl;
  logic [1:0]         ImmSrc;
  logic [1:0]         RegSrc;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  instr, alu_flags,
`ifdef MEM_HANDSHAKE_EN
    input  mem_ready,
`endif
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, ImmSrc, RegSrc, state_dbg
  );

  modport slave (
    output instr, alu_flags,
`ifdef MEM_HANDSHAKE_EN
    output mem_ready,
`endif
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUControl, ImmSrc, RegSrc, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multicycle_controller                                              |
// | Fetch/decode/execute/mem/writeback FSM with NZCV flags and cond    |
// | evaluation. Define MEM_HANDSHAKE_EN for mem_ready wait states.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH    = STATE_W'(0),
    DECODE   = STATE_W'(1),
    MEMADR   = STATE_W'(2),
    MEMREAD  = STATE_W'(3),
    MEMWB    = STATE_W'(4),
    MEMWRITE = STATE_W'(5),
    EXECUTER = STATE_W'(6),
    EXECUTEI = STATE_W'(7),
    ALUWB    = STATE_W'(8),
    BRANCH   = STATE_W'(9),
    WAITMEM  = STATE_W'(10)
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q;

  logic [1:0] op;
  logic       imm_bit;
  logic [3:0] cmd;
  logic       s_bit;
  logic [3:0] rd;
  logic [3:0] cond;
  logic       unused_bits;

  assign op          = bus.instr[27:26];
  assign imm_bit     = bus.instr[25];
  assign cmd         = bus.instr[24:21];
  assign s_bit       = bus.instr[20];
  assign rd          = bus.instr[15:12];
  assign cond        = bus.instr[31:28];
  assign unused_bits = ^{bus.instr[19:16], bus.instr[11:0]};

  logic flag_n, flag_z, flag_c, flag_v, cond_ex;
  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'h0: cond_ex = flag_z;
      4'h1: cond_ex = !flag_z;
      4'h2: cond_ex = flag_c;
      4'h3: cond_ex = !flag_c;
      4'h4: cond_ex = flag_n;
      4'h5: cond_ex = !flag_n;
      4'h6: cond_ex = flag_v;
      4'h7: cond_ex = !flag_v;
      4'h8: cond_ex = flag_c && !flag_z;
      4'h9: cond_ex = !flag_c || flag_z;
      4'hA: cond_ex = (flag_n == flag_v);
      4'hB: cond_ex = (flag_n != flag_v);
      4'hC: cond_ex = !flag_z && (flag_n == flag_v);
      4'hD: cond_ex = flag_z || (flag_n != flag_v);
      4'hE: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Unknown commands run as ADD but never write back.
  logic [1:0] cmd_alu;
  logic       cmd_valid, is_cmp, is_logic;

  always_comb begin
    cmd_alu   = 2'b00;
    cmd_valid = 1'b1;
    is_cmp    = 1'b0;
    is_logic  = 1'b0;
    case (cmd)
      4'b0100: cmd_alu = 2'b00;
      4'b0010: cmd_alu = 2'b01;
      4'b0000: begin cmd_alu = 2'b10; is_logic = 1'b1; end
      4'b1100: begin cmd_alu = 2'b11; is_logic = 1'b1; end
      4'b1010: begin cmd_alu = 2'b01; is_cmp = 1'b1; end
      default: cmd_valid = 1'b0;
    endcase
  end

  logic mem_ok;
`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = bus.mem_ready;

  state_t ret_q;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      ret_q <= FETCH;
    end else if (state_q != WAITMEM) begin
      ret_q <= state_q;
    end
  end
`else
  assign mem_ok = 1'b1;
`endif

  logic load_flags;
  assign load_flags = ((state_q == EXECUTER) || (state_q == EXECUTEI)) &&
                      cond_ex && (s_bit || is_cmp);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (load_flags) begin
        if (is_logic) begin
          flags_q[3:2] <= bus.alu_flags[3:2];
        end else begin
          flags_q <= bus.alu_flags;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = 2'b00;
    bus.ResultSrc  = 2'b00;
    bus.ALUControl = 2'b00;
    bus.ImmSrc     = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    bus.RegSrc     = {(op == 2'b01) && !s_bit, op == 2'b10};

    case (state_q)
      FETCH: begin
        bus.IRWrite   = mem_ok;
        bus.PCWrite   = mem_ok;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        state_d       = mem_ok ? DECODE : WAITMEM;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (op)
          2'b00:   state_d = imm_bit ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        state_d     = s_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        state_d    = mem_ok ? MEMWB : WAITMEM;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = cond_ex;
        bus.PCWrite   = cond_ex && (rd == 4'hF);
        state_d       = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = cond_ex && mem_ok;
        state_d      = mem_ok ? FETCH : WAITMEM;
      end
      EXECUTER: begin
        bus.ALUControl = cmd_alu;
        state_d        = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = cmd_alu;
        state_d        = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = cond_ex && cmd_valid && !is_cmp;
        bus.PCWrite  = cond_ex && (rd == 4'hF);
        state_d      = FETCH;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ImmSrc    = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = cond_ex;
        state_d       = FETCH;
      end
`ifdef MEM_HANDSHAKE_EN
      WAITMEM: begin
        bus.AdrSrc = (ret_q == MEMREAD) || (ret_q == MEMWRITE);
        state_d    = mem_ok ? ret_q : WAITMEM;
      end
`endif
      default: state_d = FETCH;
    endcase

    // Reset blocks every write and parks the selects at their fetch values.
    if (reset) begin
      bus.PCWrite    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.ALUSrcA    = 1'b1;
      bus.ALUSrcB    = 2'b10;
      bus.ResultSrc  = 2'b10;
      bus.ALUControl = 2'b00;
    end
  end

  assign bus.state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multicycle_controller                                           |
// | Scoreboard bench: per-cycle expected control vectors vs the DUT.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_multicycle_controller;

  localparam logic [31:0] C_ADD   = 32'hE0821003;
  localparam logic [31:0] C_LDR   = 32'hE5921004;
  localparam logic [31:0] C_STR   = 32'hE5821004;
  localparam logic [31:0] C_SUBS  = 32'hE0521003;
  localparam logic [31:0] C_ADDEQ = 32'h00821003;
  localparam logic [31:0] C_ADDNE = 32'h10821003;
  localparam logic [31:0] C_ADDCS = 32'h20821003;
  localparam logic [31:0] C_ADDMI = 32'h40821003;
  localparam logic [31:0] C_ADDVS = 32'h60821003;
  localparam logic [31:0] C_STREQ = 32'h05821004;
  localparam logic [31:0] C_CMP   = 32'hE1520003;
  localparam logic [31:0] C_ANDS  = 32'hE0121003;
  localparam logic [31:0] C_MOV   = 32'hE1A01003;
  localparam logic [31:0] C_ORRI  = 32'hE3821003;
  localparam logic [31:0] C_ADDPC = 32'hE082F003;
  localparam logic [31:0] C_B     = 32'hEAFFFFFE;
  localparam logic [31:0] C_NOP   = 32'hEC000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

`ifdef MEM_HANDSHAKE_EN
  assign bus.mem_ready = mem_ready;
`endif

  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
  //  ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc}
  logic [19:0] obs;
  assign obs = {bus.state_dbg, bus.PCWrite, bus.AdrSrc, bus.MemWrite,
                bus.IRWrite, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ResultSrc, bus.ALUControl, bus.ImmSrc, bus.RegSrc};

  typedef struct packed {
    logic [31:0] ins;
    logic [3:0]  fl;
    logic        rdy;
    logic        rs;
  } stim_t;

  stim_t       stimq[$];
  logic [19:0] expq[$];
  stim_t       s;
  logic [19:0] e;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [19:0] ev(input logic [3:0] st, input logic pcw,
      input logic adr, input logic mw, input logic irw, input logic rw,
      input logic sa, input logic [1:0] sb, input logic [1:0] rsel,
      input logic [1:0] ac, input logic [1:0] im, input logic [1:0] rg);
    return {st, pcw, adr, mw, irw, rw, sa, sb, rsel, ac, im, rg};
  endfunction

  task automatic push_cyc(input logic [31:0] ins, input logic [3:0] fl,
                          input logic rdy, input logic rs, input logic [19:0] x);
    stimq.push_back('{ins: ins, fl: fl, rdy: rdy, rs: rs});
    expq.push_back(x);
  endtask

  task automatic push_fd(input logic [31:0] ins, input logic [1:0] im, input logic [1:0] rg);
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd0, 1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, im, rg));
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, im, rg));
  endtask

  task automatic push_dp(input logic [31:0] ins, input logic [3:0] fl, input logic imm,
                         input logic [1:0] ac, input logic rw, input logic pcw);
    push_fd(ins, 2'b00, 2'b00);
    push_cyc(ins, fl, 1'b1, 1'b0, ev(imm ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0,
                                     imm ? 2'b01 : 2'b00, 2'b00, ac, 2'b00, 2'b00));
    push_cyc(ins, fl, 1'b1, 1'b0, ev(4'd8, pcw, 0, 0, 0, rw, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask

  task automatic push_ldr(input logic [31:0] ins, input logic rw);
    push_fd(ins, 2'b01, 2'b00);
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd3, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd4, 0, 0, 0, 0, rw, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00));
  endtask

  task automatic push_str(input logic [31:0] ins, input logic mw);
    push_fd(ins, 2'b01, 2'b10);
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10));
    push_cyc(ins, 4'h0, 1'b1, 1'b0, ev(4'd5, 0, 1, mw, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
  endtask

  task automatic apply_stim();
    s = stimq.pop_front();
    e = expq.pop_front();
    bus.instr     = s.ins;
    bus.alu_flags = s.fl;
    mem_ready     = s.rdy;
    rst           = s.rs;
  endtask

  task automatic test_reset();
    bus.instr = C_ADD;
    bus.alu_flags = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    push_cyc(C_ADD, 4'h0, 1'b1, 1'b1, ev(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    push_dp(C_ADD, 4'hF, 1'b0, 2'b00, 1'b1, 1'b0);
    push_dp(C_ADDEQ, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_add obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_store();
    push_ldr(C_LDR, 1'b1);
    push_str(C_STR, 1'b1);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_store obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cond_flags();
    push_dp(C_SUBS, 4'b0100, 1'b0, 2'b01, 1'b1, 1'b0);
    push_dp(C_ADDEQ, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0);
    push_dp(C_SUBS, 4'b0000, 1'b0, 2'b01, 1'b1, 1'b0);
    push_dp(C_ADDEQ, 4'b0100, 1'b0, 2'b00, 1'b0, 1'b0);
    push_str(C_STREQ, 1'b0);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL cond_flags obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_logic_flags();
    push_dp(C_CMP, 4'b0011, 1'b0, 2'b01, 1'b0, 1'b0);
    push_dp(C_ANDS, 4'b1000, 1'b0, 2'b10, 1'b1, 1'b0);
    push_dp(C_ADDCS, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    push_dp(C_ADDVS, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    push_dp(C_ADDMI, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    push_dp(C_ADDEQ, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL logic_flags obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_misc();
    push_fd(C_B, 2'b10, 2'b01);
    push_cyc(C_B, 4'h0, 1'b1, 1'b0, ev(4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b10, 2'b01));
    push_fd(C_NOP, 2'b00, 2'b00);
    push_dp(C_MOV, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    push_dp(C_ORRI, 4'h0, 1'b1, 2'b11, 1'b1, 1'b0);
    push_dp(C_ADDPC, 4'h0, 1'b0, 2'b00, 1'b1, 1'b1);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch_misc obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_ldr();
    push_dp(C_SUBS, 4'b0100, 1'b0, 2'b01, 1'b1, 1'b0);
    push_fd(C_LDR, 2'b01, 2'b00);
    push_cyc(C_LDR, 4'h0, 1'b1, 1'b0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00));
    push_cyc(C_LDR, 4'h0, 1'b1, 1'b0, ev(4'd3, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00));
    push_cyc(C_LDR, 4'h0, 1'b1, 1'b1, ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00));
    push_cyc(C_LDR, 4'h0, 1'b1, 1'b1, ev(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00));
    push_cyc(C_LDR, 4'h0, 1'b1, 1'b1, ev(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00));
    push_dp(C_ADDEQ, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0);
    push_dp(C_ADDNE, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask

`ifdef MEM_HANDSHAKE_EN
  task automatic test_handshake();
    push_cyc(C_ADD, 4'h0, 1'b0, 1'b0, ev(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00));
    push_cyc(C_ADD, 4'h0, 1'b0, 1'b0, ev(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push_cyc(C_ADD, 4'h0, 1'b1, 1'b0, ev(4'd10, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00));
    push_dp(C_ADD, 4'h0, 1'b0, 2'b00, 1'b1, 1'b0);
    push_fd(C_STR, 2'b01, 2'b10);
    push_cyc(C_STR, 4'h0, 1'b1, 1'b0, ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10));
    push_cyc(C_STR, 4'h0, 1'b0, 1'b0, ev(4'd5, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
    push_cyc(C_STR, 4'h0, 1'b1, 1'b0, ev(4'd10, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
    push_cyc(C_STR, 4'h0, 1'b1, 1'b0, ev(4'd5, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10));
    while (expq.size() != 0) begin
      apply_stim();
      #1;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL handshake obs=%h exp=%h", obs, e);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_store();
    test_cond_flags();
    test_logic_flags();
    test_branch_misc();
    test_reset_mid_ldr();
`ifdef MEM_HANDSHAKE_EN
    test_handshake();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=%h exp=finish", obs);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle processor core.
- Sequences fetch, decode, execute, memory and writeback for the 32-bit instructions held in instruction_memory and its field decoder.
- Drives every enable and mux select on the shared datapath: PC, instruction register, register file, ALU, data memory.
- Holds the architectural NZCV flags and evaluates the cond field.

Parameters:
- STATE_W, 4, width of the state register (must hold 11 states).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  current instruction-register contents.
- alu_flags  in  4  ALU {N,Z,C,V} for the current ALU operation.
- PCWrite  out  1  PC register load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register load enable.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = Rn, 1 = PC.
- ALUSrcB  out  2  ALU B select: 00 = Rm/shifted, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = read data, 10 = ALUResult.
- ALUControl  out  2  ALU operation: 00 = ADD, 01 = SUB, 10 = AND, 11 = ORR.
- ImmSrc  out  2  extend mode: 00 = imm8/rot, 01 = imm12, 10 = imm24 branch.
- RegSrc  out  2  [0] = 1 reads R15 for Rn; [1] = 1 reads Rd for Rm (STR).
- state_dbg  out  STATE_W  current state, for debug.

Behaviour:
- Field decode: op = instr[27:26], I = instr[25], cmd = instr[24:21], S = instr[20], L = instr[20] (op 01), Rd = instr[15:12], cond = instr[31:28].
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9, WAITMEM 10.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR if op = 01; EXECUTER if op = 00 and I = 0; EXECUTEI if op = 00 and I = 1; BRANCH if op = 10; FETCH if op = 11.
  - MEMADR -> MEMREAD if L = 1, else MEMWRITE.
  - MEMREAD -> MEMWB -> FETCH.
  - MEMWRITE -> FETCH.
  - EXECUTER / EXECUTEI -> ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - WAITMEM exists only with the optional feature.
- Latencies: branch 3 cycles; data processing 4; STR 4; LDR 5; op 11 is a 2-cycle NOP.
- Outputs are combinational from state and instr. Any unlisted output is 0.
- FETCH: AdrSrc = 0, IRWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ALUControl = 00, ResultSrc = 10, PCWrite = 1 (PC <= PC + 4).
- DECODE: ALUSrcA = 1, ALUSrcB = 10, ResultSrc = 10 (PC + 8 ready for R15 reads). RegSrc and ImmSrc are decoded from op, as in every state.
- MEMADR: ALUSrcB = 01, ALUControl = 00.
- MEMREAD: AdrSrc = 1.
- MEMWRITE: AdrSrc = 1, MemWrite = CondEx.
- MEMWB: ResultSrc = 01, RegWrite = CondEx. Also PCWrite = CondEx if Rd = 15.
- EXECUTER: ALUSrcB = 00, ALUControl from cmd.
- EXECUTEI: ALUSrcB = 01, ALUControl from cmd.
- ALUWB: ResultSrc = 00, RegWrite = CondEx and not CMP, PCWrite = CondEx and Rd = 15.
- BRANCH: ALUSrcB = 01, ImmSrc = 10, ResultSrc = 10, PCWrite = CondEx.
- cmd mapping:
  - 0100 ADD -> 00; 0010 SUB -> 01; 0000 AND -> 10; 1100 ORR -> 11; 1010 CMP -> 01 with no RegWrite.
  - Any other cmd -> ALUControl 00 and RegWrite forced 0.
- Flags: internal 4-bit register, reset to 0000.
  - Loads alu_flags at the end of EXECUTER/EXECUTEI when S = 1 and CondEx = 1. CMP always loads (subject to CondEx).
  - For AND/ORR only N and Z update; C and V are held.
- CondEx is evaluated against the registered flags:
  - Codes 0000–1101 are EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE.
  - 1110 is always true; 1111 is false.
  - A false condition still walks the full state path, but MemWrite, RegWrite, flag load and non-FETCH PCWrite stay 0.
- Reset:
  - While reset = 1, all enable outputs (PCWrite, MemWrite, IRWrite, RegWrite) are forced 0 combinationally.
  - The selects take their FETCH values.
  - On the clock edge the state becomes FETCH and the flags become 0. Reset mid-instruction abandons it with no partial write.
  - First fetch occurs on the first edge after reset deasserts.

Optional Feature:
- MEM_HANDSHAKE_EN: adds input port mem_ready (1 bit).
- FETCH, MEMREAD and MEMWRITE advance only when mem_ready = 1. Otherwise the FSM enters WAITMEM:
  - PCWrite, IRWrite, MemWrite and RegWrite are held 0.
  - The entry state is recorded in an internal return field.
  - AdrSrc is held at its entry-state value.
- When mem_ready = 1, the FSM returns to the recorded state, which then performs its normal cycle.
- Without the macro: no port, no WAITMEM, memory is single-cycle.

Test Plan:
- Reset held 3 cycles mid-LDR -> RegWrite/PCWrite/MemWrite stay 0; state_dbg = 0 on release; flags = 0000.
- instr 0xE0821003 (ADD R1,R2,R3) -> states 0,1,6,8; RegWrite = 1 only in ALUWB; ALUControl = 00; flags unchanged.
- instr 0xE5921004 (LDR) -> states 0,1,2,3,4; AdrSrc = 1 in MEMREAD; RegWrite with ResultSrc = 01 in MEMWB. Then 0xE5821004 (STR) -> MemWrite = 1 for one cycle in state 5.
- instr 0xE0521003 (SUBS) with alu_flags = 0100, then 0x00821003 (ADDEQ) -> RegWrite = 1. Repeat with alu_flags = 0000 -> ADDEQ has RegWrite = 0 yet still traverses states 6, 8.
- instr 0xEAFFFFFE (B) -> states 0,1,9; ImmSrc = 10 and PCWrite = 1 in BRANCH; 3 cycles total.
- MEM_HANDSHAKE_EN: mem_ready low 2 cycles during FETCH -> IRWrite/PCWrite 0 for those cycles, state 10; then the FETCH cycle completes once.
